// File: rtl/hazard_pkg.sv
// Shared encodings for the hazard/forwarding unit.
//   hz_state_e : registered hazard state reported on hz_state.
//   FWD_*      : per-channel operand-select codes driven on fwd_sel.
package hazard_pkg;

  typedef enum logic [1:0] {
    StRun      = 2'd0,
    StLdBubble = 2'd1,
    StMemWait  = 2'd2,
    StMcWait   = 2'd3
  } hz_state_e;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_match.sv
// One forwarding channel: operand select plus load-use and multicycle match flags.
// Ports:
//   rs, rs_used                   source address and "actually read" flag
//   ex_rd, ex_load_wr             EX destination; EX holds a register-writing load
//   mem_rd/mem_reg_write          MEM destination / write enable
//   wb_rd/wb_reg_write            WB destination / write enable
//   pending                       multicycle scoreboard bits
//   mc_done, mc_done_rd           multicycle result in WB this cycle
//   sel                           operand select (FWD_RF / FWD_WB / FWD_MEM)
//   load_match, mc_match          this channel depends on a load in EX / a pending mc op
module fwd_match
  import hazard_pkg::*;
#(
  parameter int unsigned AW        = 5,
  parameter int unsigned WB_FWD_EN = 1
) (
  input  logic [AW-1:0]      rs,
  input  logic               rs_used,
  input  logic [AW-1:0]      ex_rd,
  input  logic               ex_load_wr,
  input  logic [AW-1:0]      mem_rd,
  input  logic               mem_reg_write,
  input  logic [AW-1:0]      wb_rd,
  input  logic               wb_reg_write,
  input  logic [2**AW-1:0]   pending,
  input  logic               mc_done,
  input  logic [AW-1:0]      mc_done_rd,
  output logic [1:0]         sel,
  output logic               load_match,
  output logic               mc_match
);

  // x0 is never forwarded and never creates a dependency.
  logic active;
  assign active = rs_used && (rs != '0);

  // rs != 0 plus equality already implies the producer's rd is nonzero.
  always_comb begin
    sel = FWD_RF;
    if (active) begin
      if (mem_reg_write && (mem_rd == rs)) begin
        sel = FWD_MEM;
      end else if ((WB_FWD_EN != 0) && wb_reg_write && (wb_rd == rs)) begin
        sel = FWD_WB;
      end
    end
  end

  assign load_match = active && ex_load_wr && (ex_rd == rs);

  // A result retiring this cycle is picked up through the WB bypass, so no stall.
  assign mc_match = active && pending[rs] && !(mc_done && (mc_done_rd == rs));

endmodule

// File: rtl/hazard_forward_unit.sv
// Pipeline hazard detection and operand forwarding.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   id_valid, id_rs, id_rs_used    ID instruction and its NSRC source operands
//   ex_rd/ex_reg_write/ex_is_load  EX-stage producer
//   mem_rd/mem_reg_write           MEM-stage producer
//   wb_rd/wb_reg_write             WB-stage producer
//   lsu_busy                       data memory stall, freezes the whole pipe
//   mc_issue/mc_rd                 multicycle op launched, marks mc_rd pending
//   mc_done/mc_done_rd             multicycle result in WB, clears pending
//   fwd_sel                        2 bits per channel operand select
//   stall_if/stall_id/bubble_ex    pipeline control
//   hz_state                       registered hazard state
//   cnt_ld/cnt_mem/cnt_mc          saturating stall-cycle counters
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned AW        = 5,
  parameter int unsigned NSRC      = 2,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned WB_FWD_EN = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NSRC*AW-1:0]   id_rs,
  input  logic [NSRC-1:0]      id_rs_used,
  input  logic [AW-1:0]        ex_rd,
  input  logic                 ex_reg_write,
  input  logic                 ex_is_load,
  input  logic [AW-1:0]        mem_rd,
  input  logic                 mem_reg_write,
  input  logic [AW-1:0]        wb_rd,
  input  logic                 wb_reg_write,
  input  logic                 lsu_busy,
  input  logic                 mc_issue,
  input  logic [AW-1:0]        mc_rd,
  input  logic                 mc_done,
  input  logic [AW-1:0]        mc_done_rd,
  output logic [2*NSRC-1:0]    fwd_sel,
  output logic                 stall_if,
  output logic                 stall_id,
  output logic                 bubble_ex,
  output logic [1:0]           hz_state,
  output logic [CNT_W-1:0]     cnt_ld,
  output logic [CNT_W-1:0]     cnt_mem,
  output logic [CNT_W-1:0]     cnt_mc
);

  localparam int unsigned NREG = 2**AW;

  logic [NREG-1:0] sb_q, sb_d, sb_set, sb_clr;
  logic [NSRC-1:0] ld_vec, mc_vec;
  logic            ex_load_wr;
  logic            load_use, mc_hazard;
  logic            win_mem, win_ld, win_mc;
  hz_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_ld_q, cnt_mem_q, cnt_mc_q;

  assign ex_load_wr = ex_is_load && ex_reg_write;

  for (genvar i = 0; i < NSRC; i++) begin : g_ch
    fwd_match #(
      .AW       (AW),
      .WB_FWD_EN(WB_FWD_EN)
    ) u_fwd_match (
      .rs           (id_rs[i*AW +: AW]),
      .rs_used      (id_rs_used[i]),
      .ex_rd        (ex_rd),
      .ex_load_wr   (ex_load_wr),
      .mem_rd       (mem_rd),
      .mem_reg_write(mem_reg_write),
      .wb_rd        (wb_rd),
      .wb_reg_write (wb_reg_write),
      .pending      (sb_q),
      .mc_done      (mc_done),
      .mc_done_rd   (mc_done_rd),
      .sel          (fwd_sel[2*i +: 2]),
      .load_match   (ld_vec[i]),
      .mc_match     (mc_vec[i])
    );
  end

  assign load_use  = id_valid && (|ld_vec);
  assign mc_hazard = id_valid && (|mc_vec);

  assign stall_if  = lsu_busy || load_use || mc_hazard;
  assign stall_id  = stall_if;
  assign bubble_ex = (load_use || mc_hazard) && !lsu_busy;

  // Exactly one winning cause per cycle.
  assign win_mem = lsu_busy;
  assign win_ld  = !lsu_busy && load_use;
  assign win_mc  = !lsu_busy && !load_use && mc_hazard;

  // Scoreboard: set wins over a same-cycle clear; x0 never becomes pending.
  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (mc_issue && (mc_rd != '0)) sb_set[mc_rd] = 1'b1;
    if (mc_done) sb_clr[mc_done_rd] = 1'b1;
    sb_d = (sb_q & ~sb_clr) | sb_set;
  end

  always_comb begin
    state_d = StRun;
    if (win_mem)     state_d = StMemWait;
    else if (win_ld) state_d = StLdBubble;
    else if (win_mc) state_d = StMcWait;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StRun;
      sb_q    <= '0;
    end else begin
      state_q <= state_d;
      sb_q    <= sb_d;
    end
  end

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_ld_q  <= '0;
      cnt_mem_q <= '0;
      cnt_mc_q  <= '0;
    end else begin
      if (win_ld && (cnt_ld_q != {CNT_W{1'b1}}))   cnt_ld_q  <= cnt_ld_q + CNT_W'(1);
      if (win_mem && (cnt_mem_q != {CNT_W{1'b1}})) cnt_mem_q <= cnt_mem_q + CNT_W'(1);
      if (win_mc && (cnt_mc_q != {CNT_W{1'b1}}))   cnt_mc_q  <= cnt_mc_q + CNT_W'(1);
    end
  end

  assign hz_state = state_q;
  assign cnt_ld   = cnt_ld_q;
  assign cnt_mem  = cnt_mem_q;
  assign cnt_mc   = cnt_mc_q;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [9:0]  id_rs;
  logic [1:0]  id_rs_used;
  logic [4:0]  ex_rd, mem_rd, wb_rd, mc_rd, mc_done_rd;
  logic        ex_reg_write, ex_is_load, mem_reg_write, wb_reg_write;
  logic        lsu_busy, mc_issue, mc_done;

  logic [3:0]  fwd_sel, fwd_sel4;
  logic        stall_if, stall_id, bubble_ex;
  logic        stall_if4, stall_id4, bubble_ex4;
  logic [1:0]  hz_state, hz_state4;
  logic [15:0] cnt_ld, cnt_mem, cnt_mc;
  logic [3:0]  cnt_ld4, cnt_mem4, cnt_mc4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hazard_forward_unit u_dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .lsu_busy(lsu_busy), .mc_issue(mc_issue), .mc_rd(mc_rd),
    .mc_done(mc_done), .mc_done_rd(mc_done_rd), .fwd_sel(fwd_sel), .stall_if(stall_if),
    .stall_id(stall_id), .bubble_ex(bubble_ex), .hz_state(hz_state), .cnt_ld(cnt_ld),
    .cnt_mem(cnt_mem), .cnt_mc(cnt_mc)
  );

  // Narrow counters and no WB bypass.
  hazard_forward_unit #(.CNT_W(4), .WB_FWD_EN(0)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rs_used(id_rs_used),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_is_load(ex_is_load),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .lsu_busy(lsu_busy), .mc_issue(mc_issue), .mc_rd(mc_rd),
    .mc_done(mc_done), .mc_done_rd(mc_done_rd), .fwd_sel(fwd_sel4), .stall_if(stall_if4),
    .stall_id(stall_id4), .bubble_ex(bubble_ex4), .hz_state(hz_state4), .cnt_ld(cnt_ld4),
    .cnt_mem(cnt_mem4), .cnt_mc(cnt_mc4)
  );

  typedef struct {
    logic       id_valid;
    logic [4:0] rs0;
    logic [4:0] rs1;
    logic [1:0] used;
    logic [4:0] ex_rd;
    logic       ex_rw;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_rw;
    logic [4:0] wb_rd;
    logic       wb_rw;
    logic       lsu;
    logic [3:0] e_sel;
    logic [3:0] e_sel4;
    logic       e_stall;
    logic       e_bub;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    id_valid = 0; id_rs = '0; id_rs_used = '0;
    ex_rd = '0; ex_reg_write = 0; ex_is_load = 0;
    mem_rd = '0; mem_reg_write = 0; wb_rd = '0; wb_reg_write = 0;
    lsu_busy = 0; mc_issue = 0; mc_rd = '0; mc_done = 0; mc_done_rd = '0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0;
    clear_inputs();
    #2;
    rst_n = 1;
  endtask

  initial begin
    //           vld rs0 rs1 used exrd rw ld memrd mw wbrd ww lsu  sel     sel4    st bub
    vecs[0]  = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0};
    vecs[1]  = '{1, 5, 0, 2'b01, 0, 0, 0, 5, 1, 5, 1, 0, 4'b0010, 4'b0010, 0, 0};
    vecs[2]  = '{1, 5, 0, 2'b01, 0, 0, 0, 5, 0, 5, 1, 0, 4'b0001, 4'b0000, 0, 0};
    vecs[3]  = '{1, 0, 0, 2'b10, 0, 0, 0, 0, 1, 0, 0, 0, 4'b0000, 4'b0000, 0, 0};
    vecs[4]  = '{1, 5, 0, 2'b00, 0, 0, 0, 5, 1, 5, 1, 0, 4'b0000, 4'b0000, 0, 0};
    vecs[5]  = '{1, 4, 3, 2'b11, 0, 0, 0, 3, 1, 4, 1, 0, 4'b1001, 4'b1000, 0, 0};
    vecs[6]  = '{1, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 1, 1};
    vecs[7]  = '{0, 7, 0, 2'b01, 7, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0};
    vecs[8]  = '{1, 7, 0, 2'b01, 7, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0};
    vecs[9]  = '{1, 0, 0, 2'b01, 0, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0};
    vecs[10] = '{1, 2, 7, 2'b11, 7, 1, 1, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0};
    vecs[11] = '{0, 0, 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 1, 4'b0000, 4'b0000, 1, 0};
    vecs[12] = '{1, 7, 0, 2'b00, 7, 1, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0};
    vecs[13] = '{1, 7, 0, 2'b01, 7, 0, 1, 0, 0, 0, 0, 0, 4'b0000, 4'b0000, 0, 0};

    clear_inputs();
    rst_n = 0;
    #1;
    chk("reset hz_state", 32'(hz_state), 32'd0);
    chk("reset cnt_ld", 32'(cnt_ld), 32'd0);
    chk("reset cnt_mem", 32'(cnt_mem), 32'd0);
    chk("reset cnt_mc", 32'(cnt_mc), 32'd0);
    #10;
    rst_n = 1;

    // Combinational forwarding and stall decode
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      id_valid = vecs[i].id_valid;
      id_rs = {vecs[i].rs1, vecs[i].rs0};
      id_rs_used = vecs[i].used;
      ex_rd = vecs[i].ex_rd; ex_reg_write = vecs[i].ex_rw; ex_is_load = vecs[i].ex_ld;
      mem_rd = vecs[i].mem_rd; mem_reg_write = vecs[i].mem_rw;
      wb_rd = vecs[i].wb_rd; wb_reg_write = vecs[i].wb_rw;
      lsu_busy = vecs[i].lsu;
      #1;
      chk($sformatf("v%0d fwd_sel", i), 32'(fwd_sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d fwd_sel_nowb", i), 32'(fwd_sel4), 32'(vecs[i].e_sel4));
      chk($sformatf("v%0d stall_if", i), 32'(stall_if), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d stall_id", i), 32'(stall_id), 32'(vecs[i].e_stall));
      chk($sformatf("v%0d bubble_ex", i), 32'(bubble_ex), 32'(vecs[i].e_bub));
    end

    // Single load-use: one bubble cycle
    do_reset();
    @(negedge clk);
    id_valid = 1; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
    ex_rd = 7; ex_reg_write = 1; ex_is_load = 1;
    #1;
    chk("lu stall", 32'({stall_if, stall_id, bubble_ex}), 32'b111);
    @(posedge clk); #1;
    chk("lu hz_state", 32'(hz_state), 32'd1);
    chk("lu cnt_ld", 32'(cnt_ld), 32'd1);
    @(negedge clk);
    ex_rd = 0; ex_reg_write = 0; ex_is_load = 0; mem_rd = 7; mem_reg_write = 1;
    #1;
    chk("lu after stall", 32'({stall_if, stall_id, bubble_ex}), 32'b000);
    chk("lu after fwd", 32'(fwd_sel), 32'b0010);
    @(posedge clk); #1;
    chk("lu after state", 32'(hz_state), 32'd0);
    chk("lu after cnt_ld", 32'(cnt_ld), 32'd1);

    // Memory stall masks the load-use bubble
    do_reset();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      id_valid = 1; id_rs = {5'd0, 5'd7}; id_rs_used = 2'b01;
      ex_rd = 7; ex_reg_write = 1; ex_is_load = 1; lsu_busy = 1;
      #1;
      chk($sformatf("mw%0d stall/bubble", c), 32'({stall_if, bubble_ex}), 32'b10);
      @(posedge clk); #1;
      chk($sformatf("mw%0d state", c), 32'(hz_state), 32'd2);
    end
    chk("mw cnt_mem", 32'(cnt_mem), 32'd3);
    chk("mw cnt_ld", 32'(cnt_ld), 32'd0);
    @(negedge clk);
    lsu_busy = 0;
    #1;
    chk("mw bubble", 32'({stall_if, bubble_ex}), 32'b11);
    @(posedge clk); #1;
    chk("mw ld state", 32'(hz_state), 32'd1);
    chk("mw ld cnt", 32'(cnt_ld), 32'd1);
    chk("mw cnt_mem hold", 32'(cnt_mem), 32'd3);

    // Multicycle dependency resolved by mc_done
    do_reset();
    @(negedge clk);
    mc_issue = 1; mc_rd = 9;
    #1;
    chk("mc issue no stall", 32'(stall_if), 32'd0);
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      mc_issue = 0; mc_rd = 0;
      id_valid = 1; id_rs = {5'd9, 5'd0}; id_rs_used = 2'b10;
      #1;
      chk($sformatf("mc%0d stall/bubble", c), 32'({stall_if, stall_id, bubble_ex}), 32'b111);
      @(posedge clk); #1;
      chk($sformatf("mc%0d state", c), 32'(hz_state), 32'd3);
    end
    chk("mc cnt_mc", 32'(cnt_mc), 32'd3);
    @(negedge clk);
    mc_done = 1; mc_done_rd = 9; wb_rd = 9; wb_reg_write = 1;
    #1;
    chk("mc done stall", 32'(stall_if), 32'd0);
    chk("mc done fwd", 32'(fwd_sel), 32'b0100);
    @(posedge clk); #1;
    chk("mc done state", 32'(hz_state), 32'd0);
    @(negedge clk);
    mc_done = 0; mc_done_rd = 0; wb_rd = 0; wb_reg_write = 0;
    #1;
    chk("mc cleared stall", 32'(stall_if), 32'd0);

    // Set beats a same-cycle clear on the same scoreboard bit
    do_reset();
    @(negedge clk);
    mc_issue = 1; mc_rd = 10;
    @(negedge clk);
    mc_done = 1; mc_done_rd = 10;
    @(negedge clk);
    mc_issue = 0; mc_rd = 0; mc_done = 0; mc_done_rd = 0;
    id_valid = 1; id_rs = {5'd0, 5'd10}; id_rs_used = 2'b01;
    #1;
    chk("set wins stall", 32'(stall_if), 32'd1);

    // Counter saturation, then reset in the middle of MC_WAIT
    do_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      lsu_busy = 1;
    end
    @(posedge clk); #1;
    chk("sat cnt_mem4", 32'(cnt_mem4), 32'd15);
    chk("wide cnt_mem", 32'(cnt_mem), 32'd20);
    @(negedge clk);
    lsu_busy = 0; mc_issue = 1; mc_rd = 9;
    @(negedge clk);
    mc_issue = 0; mc_rd = 0;
    id_valid = 1; id_rs = {5'd9, 5'd0}; id_rs_used = 2'b10;
    @(posedge clk); #1;
    chk("pre-rst state", 32'(hz_state), 32'd3);
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    chk("rst state", 32'(hz_state), 32'd0);
    chk("rst cnt_mem", 32'(cnt_mem), 32'd0);
    chk("rst cnt_mc", 32'(cnt_mc), 32'd0);
    chk("rst cnt_mem4", 32'(cnt_mem4), 32'd0);
    chk("rst stall", 32'(stall_if), 32'd0);
    #1;
    rst_n = 1;
    @(negedge clk); #1;
    chk("post-rst sb clear", 32'(stall_if), 32'd0);
    @(posedge clk); #1;
    chk("post-rst state", 32'(hz_state), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
